mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch requester (IF) and the data requester (lw/sw path driven by MemRead/MemWrite decode).
- Arbitrates, issues exactly one memory access at a time, waits the fixed read latency and returns read data or write completion to the winner.
- Data has priority; a starvation counter guarantees fetch progress.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 2, memory read latency in cycles (mem_en cycle to mem_rdata valid), legal 1..15
MAX_WAIT, 3, consecutive fetch losses before fetch is forced to win, legal 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  one-cycle grant pulse to fetch
if_rvalid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DW  fetched word
d_req  in  1  data request, held until d_gnt
d_we  in  1  1=store (sw), 0=load (lw)
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_gnt  out  1  one-cycle grant pulse to data
d_rvalid  out  1  one-cycle pulse, load data valid
d_rdata  out  DW  loaded word
d_done  out  1  one-cycle pulse, store complete
mem_en  out  1  memory access strobe, exactly one cycle per access
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: reset is synchronous, active-high. State=IDLE; all strobes (gnts, rvalids, d_done, mem_en, mem_we) 0; rdata, mem_addr and mem_wdata 0; starvation counter 0.
- Reset mid-access: the in-flight access is abandoned and no rvalid/done is produced. The memory side is not reset by this block.
- States and transitions:
  - IDLE: arbitrate. If a winner exists -> ISSUE, else stay.
  - ISSUE (1 cycle): winner's gnt=1, mem_en=1, mem_we=winner is data & d_we; mem_addr/mem_wdata hold values registered at arbitration. Load/fetch -> WAIT. Store -> DONE.
  - WAIT: counter runs MEM_LAT cycles from the mem_en cycle. On the cycle mem_rdata is valid, capture it into the winner's rdata register -> DONE.
  - DONE (1 cycle): pulse the winner's rvalid (reads) or d_done (stores). Arbitrate again as in IDLE: winner -> ISSUE, none -> IDLE.
- Arbitration is sampled at the end of IDLE/DONE cycles:
  - Only one requester active: it wins.
  - Both active: data wins unless wait_cnt == MAX_WAIT, in which case fetch wins.
- wait_cnt:
  - +1 on each arbitration where both request and data wins.
  - Cleared when fetch wins or when if_req=0 at an arbitration.
  - Saturates at MAX_WAIT.
- Timing, request sampled at cycle t:
  - gnt and mem_en at t+1.
  - Read: mem_rdata valid at t+1+MEM_LAT; rvalid and rdata at t+2+MEM_LAT; next mem_en no earlier than t+3+MEM_LAT.
  - Store: d_done at t+2; next mem_en no earlier than t+3.
- Requests arriving in ISSUE/WAIT are not sampled; requesters hold req until they see gnt.
- A req still high in DONE after that requester was just served is treated as a new request.
- rdata registers hold their last value until the next capture. Only one of if_gnt/d_gnt, and only one of if_rvalid/d_rvalid/d_done, is high in any cycle.

Test Plan:
- MEM_LAT=2, fetch-only: if_req=1, if_addr=0x40 at t=0; mem returns 0x2002000A at t=3 -> if_gnt and mem_en (mem_we=0, mem_addr=0x40) at t=1; if_rvalid=1 with if_rdata=0x2002000A at t=4.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF at t=0 -> d_gnt, mem_en, mem_we at t=1 with addr/data as given; d_done at t=2; busy low at t=3.
- Simultaneous if_req and d_req (load, addr 0x8) at t=0 -> d_gnt at t=1; d_rvalid at t=4 with if_gnt low; if_gnt at t=5.
- Starvation, MAX_WAIT=3: if_req and d_req held continuously -> data wins 3 consecutive arbitrations, fetch wins the 4th, then the counter restarts at 0.
- Reset at t=2 during a fetch read -> all outputs 0 at t=3; no if_rvalid ever; new request after reset is granted normally.
- Back-to-back: d_req held high through DONE -> the second mem_en occurs exactly one cycle after the d_rvalid/d_done pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and data load/store
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       win_d;
    logic       win_we;
    logic [3:0] lat_cnt;
    logic [3:0] wait_cnt;
    logic       arb;
    logic       pick_d;
    logic       any_req;
    logic       lat_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Data wins a contested arbitration unless fetch has already lost MAX_WAIT in a row.
    always_comb begin
        arb       = (state == IDLE) || (state == DONE);
        any_req   = if_req || d_req;
        pick_d    = d_req && (!if_req || (wait_cnt != 4'(MAX_WAIT)));
        lat_hit   = (lat_cnt == 4'(MEM_LAT));
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = any_req ? ISSUE : IDLE;
            ISSUE:      state_nxt = win_we ? DONE : WAIT;
            WAIT:       state_nxt = lat_hit ? DONE : WAIT;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_d     <= 1'b0;
            win_we    <= 1'b0;
            lat_cnt   <= 4'd0;
            wait_cnt  <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (arb && any_req) begin
                win_d     <= pick_d;
                win_we    <= pick_d && d_we;
                mem_addr  <= pick_d ? d_addr : if_addr;
                mem_wdata <= pick_d ? d_wdata : '0;
            end
            if (arb) begin
                if (!if_req || !pick_d) begin
                    wait_cnt <= 4'd0;
                end else if (wait_cnt != 4'(MAX_WAIT)) begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
            end
            // lat_cnt counts the mem_en cycle as 1, so a hit marks the cycle mem_rdata is valid.
            if (state == ISSUE) begin
                lat_cnt <= 4'd1;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt + 4'd1;
                if (lat_hit) begin
                    if (win_d) begin
                        d_rdata <= mem_rdata;
                    end else begin
                        if_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign busy      = (state != IDLE);
    assign mem_en    = (state == ISSUE);
    assign mem_we    = (state == ISSUE) && win_we;
    assign if_gnt    = (state == ISSUE) && !win_d;
    assign d_gnt     = (state == ISSUE) && win_d;
    assign if_rvalid = (state == DONE) && !win_d;
    assign d_rvalid  = (state == DONE) && win_d && !win_we;
    assign d_done    = (state == DONE) && win_d && win_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MEM_LAT  = 2;
    localparam int MAX_WAIT = 3;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        longint      g;
        longint      r;
        bit          isd;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } tr_t;

    typedef struct {
        longint      c;
        logic [31:0] d;
    } rd_t;

    tr_t         sb[$];
    rd_t         pipe[$];
    logic [31:0] ref_mem[16];
    logic [31:0] tb_mem[16];
    longint      cyc = 0;
    longint      next_arb = 0;
    longint      zero_cyc = -1;
    int          wcnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          prob = 40;
    bit          stop = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: serial transactions placed on a cycle timeline by the arbitration rules.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            sb.delete();
            wcnt     = 0;
            next_arb = cyc + 1;
            zero_cyc = cyc + 1;
        end else if (cyc == next_arb) begin
            if (!if_req && !d_req) begin
                wcnt     = 0;
                next_arb = cyc + 1;
            end else begin
                tr_t t;
                bit  fetch_wins;
                fetch_wins = if_req && (!d_req || wcnt == MAX_WAIT);
                if (fetch_wins || !if_req) wcnt = 0;
                else if (wcnt < MAX_WAIT) wcnt = wcnt + 1;
                t.isd   = !fetch_wins;
                t.we    = t.isd && d_we;
                t.addr  = t.isd ? d_addr : if_addr;
                t.wdata = d_wdata;
                t.g     = cyc + 1;
                t.r     = t.we ? cyc + 2 : cyc + 2 + MEM_LAT;
                t.rdata = ref_mem[t.addr[5:2]];
                if (t.we) ref_mem[t.addr[5:2]] = t.wdata;
                next_arb = t.r;
                sb.push_back(t);
            end
        end
        cyc = cyc + 1;
    end

    // Behavioural memory: read data valid only on the cycle MEM_LAT after mem_en, junk otherwise.
    initial forever begin
        @(negedge clk);
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) begin
                tb_mem[mem_addr[5:2]] = mem_wdata;
            end else begin
                rd_t e;
                e.c = cyc + MEM_LAT;
                e.d = tb_mem[mem_addr[5:2]];
                pipe.push_back(e);
            end
        end
    end

    initial begin
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            while (pipe.size() > 0 && pipe[0].c < cyc) void'(pipe.pop_front());
            if (pipe.size() > 0 && pipe[0].c == cyc) mem_rdata = pipe.pop_front().d;
            else mem_rdata = $urandom;
        end
    end

    // Monitor: compares DUT outputs each cycle against the head of the scoreboard.
    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            logic [7:0] e;
            logic [7:0] a;
            bit         have;
            tr_t        h;
            e    = '0;
            have = sb.size() > 0;
            if (have) h = sb[0];
            if (have && h.g == cyc) begin
                e[7] = !h.isd;
                e[6] = h.isd;
                e[5] = 1'b1;
                e[4] = h.we;
            end
            if (have && h.r == cyc) begin
                e[3] = !h.isd;
                e[2] = h.isd && !h.we;
                e[1] = h.isd && h.we;
            end
            e[0] = have && h.g <= cyc;
            a = {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, d_done, busy};
            check("strobes", 64'(a), 64'(e));
            if (e[5]) check("mem_addr", 64'(mem_addr), 64'(h.addr));
            if (e[5] && h.we) check("mem_wdata", 64'(mem_wdata), 64'(h.wdata));
            if (e[3]) check("if_rdata", 64'(if_rdata), 64'(h.rdata));
            if (e[2]) check("d_rdata", 64'(d_rdata), 64'(h.rdata));
            if (zero_cyc == cyc)
                check("reset_zero", 64'({if_rdata, d_rdata} | {mem_addr, mem_wdata}), 64'd0);
            if (have && h.r == cyc) void'(sb.pop_front());
        end
    end

    // Requesters: hold req until granted, then randomly re-request (possibly at once).
    initial begin
        logic gi;
        logic gd;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        forever begin
            @(negedge clk);
            gi = if_gnt;
            gd = d_gnt;
            @(posedge clk);
            #1;
            if (if_req && gi === 1'b1) if_req = 1'b0;
            if (d_req && gd === 1'b1) d_req = 1'b0;
            if (!if_req && !stop && !reset && $urandom_range(0, 99) < prob) begin
                if_req  = 1'b1;
                if_addr = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!d_req && !stop && !reset && $urandom_range(0, 99) < prob) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
                d_wdata = $urandom;
            end
        end
    end

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            tb_mem[i]  = ref_mem[i];
        end
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (1200) @(posedge clk);
        #1;
        pulse_reset();
        prob = 100;
        repeat (1000) @(posedge clk);
        #1;
        pulse_reset();
        prob = 60;
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(30, 250)) @(posedge clk);
            #1;
            pulse_reset();
        end
        repeat (800) @(posedge clk);
        stop = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("drained", 64'(sb.size()), 64'd0);
        check("idle_at_end", 64'(busy), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
